axi_rd_arbiter: RTL and testbench

//  Shares one AXI3 read master port (AR/R) among N read requesters: icache refill, dcache refill, data uncache.

---
 rtl/axi_rd_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 read master port among N requesters: AR arbitration with ID stamping, R routing by RID.
// Define ARB_RR_EN for round-robin arbitration; default build is fixed priority (index 0 highest).
module axi_rd_arbiter #(
  parameter int N       = 3,
  parameter int MAX_OUT = 2,
  parameter int ID_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      s_arvalid,
  input  logic [N*32-1:0]   s_araddr,
  input  logic [N*4-1:0]    s_arlen,
  input  logic [N*3-1:0]    s_arsize,
  output logic [N-1:0]      s_arready,
  output logic [N-1:0]      s_rvalid,
  input  logic [N-1:0]      s_rready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic [ID_W-1:0]   m_arid,
  output logic [31:0]       m_araddr,
  output logic [3:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              rid_err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt [N];
  logic [31:0]        r_araddr;
  logic [3:0]         r_arlen;
  logic [2:0]         r_arsize;
  logic [ID_W-1:0]    r_arid;
  logic               r_rid_err;

  logic [N-1:0]       w_elig;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic               w_grant;
  logic [31:0]        w_sel_addr;
  logic [3:0]         w_sel_len;
  logic [2:0]         w_sel_size;
  logic [N-1:0]       w_inc;
  logic [N-1:0]       w_dec;
  logic               w_rready_sel;
  logic               w_rid_ok;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_elig[i] = s_arvalid[i] && (r_cnt[i] < CNT_MAX);
    end
  end

`ifdef ARB_RR_EN
  logic [IDX_W-1:0] r_rr;
  int               w_idx;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      for (int i = 0; i < N; i++) begin
        if (!w_found && (i == w_idx) && w_elig[i]) begin
          w_found = 1'b1;
          w_win   = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= '0;
    end else if (w_grant) begin
      r_rr <= (int'(w_win) == N - 1) ? '0 : w_win + 1'b1;
    end
  end
`else
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    m_arvalid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_arvalid = 1'b1;
        if (m_arready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_arready  = '0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    w_sel_size = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win == IDX_W'(i)) begin
        s_arready[i] = w_grant;
        w_sel_addr   = s_araddr[32*i +: 32];
        w_sel_len    = s_arlen[4*i +: 4];
        w_sel_size   = s_arsize[3*i +: 3];
      end
    end
  end

  // AR fields only move on a grant, so they stay stable throughout ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_araddr <= '0;
      r_arlen  <= '0;
      r_arsize <= '0;
      r_arid   <= '0;
    end else if (w_grant) begin
      r_araddr <= w_sel_addr;
      r_arlen  <= w_sel_len;
      r_arsize <= w_sel_size;
      r_arid   <= ID_W'(w_win);
    end
  end

  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign m_arsize  = r_arsize;
  assign m_arid    = r_arid;
  assign m_arburst = (r_arlen != 4'd0) ? 2'b01 : 2'b00;

  // Unknown IDs match no requester, so the beat is accepted and dropped
  always_comb begin
    s_rvalid     = '0;
    w_rready_sel = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (m_rid == ID_W'(i)) begin
        s_rvalid[i]  = m_rvalid;
        w_rready_sel = s_rready[i];
      end
    end
  end

  assign m_rready = w_rready_sel;
  assign w_rid_ok = (32'(m_rid) < 32'(N));
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_inc[i] = s_arvalid[i] && s_arready[i];
      w_dec[i] = m_rvalid && m_rready && m_rlast && (m_rid == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       r_rid_err <= 1'b0;
    else if (m_rvalid && !w_rid_ok) r_rid_err <= 1'b1;
  end

  assign rid_err = r_rid_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: R-routing vector table, directed corner sequences, random run vs reference model.
module tb_axi_rd_arbiter;
  localparam int N       = 3;
  localparam int MAX_OUT = 2;
  localparam int ID_W    = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      s_arvalid;
  logic [N*32-1:0]   s_araddr;
  logic [N*4-1:0]    s_arlen;
  logic [N*3-1:0]    s_arsize;
  logic [N-1:0]      s_arready;
  logic [N-1:0]      s_rvalid;
  logic [N-1:0]      s_rready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic [ID_W-1:0]   m_arid;
  logic [31:0]       m_araddr;
  logic [3:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid;
  logic              m_arready;
  logic [ID_W-1:0]   m_rid;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;
  logic              rid_err;

  axi_rd_arbiter #(.N(N), .MAX_OUT(MAX_OUT), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .rid_err(rid_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: pending AR slot, outstanding counts, rr pointer, sticky error
  int          md_cnt [N];
  bit          md_pend;
  logic [31:0] md_addr;
  logic [3:0]  md_len;
  logic [2:0]  md_size;
  int          md_id;
  int          md_rr;
  bit          md_err;

  logic [N-1:0] obs_arready, obs_srvalid;
  logic         obs_mrready, obs_marvalid, obs_riderr;
  logic [ID_W-1:0] obs_arid;
  logic [31:0]  obs_araddr;
  logic [3:0]   obs_arlen;
  logic [1:0]   obs_arburst;

  typedef struct {
    logic         mrv;
    logic [3:0]   rid;
    logic [N-1:0] rr;
    logic [N-1:0] exp_srv;
    logic         exp_mrr;
  } rvec_t;
  rvec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) md_cnt[i] = 0;
    md_pend = 1'b0; md_addr = '0; md_len = '0; md_size = '0;
    md_id = 0; md_rr = 0; md_err = 1'b0;
  endtask

  task automatic idle_inputs();
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
    s_rready = '1; m_arready = 1'b0; m_rid = '0; m_rdata = '0;
    m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] l, input logic [2:0] s);
    s_araddr[32*i +: 32] = a;
    s_arlen[4*i +: 4]    = l;
    s_arsize[3*i +: 3]   = s;
  endtask

  // Entered just after a rising edge with inputs set: check at negedge, then advance the model.
  task automatic cycle();
    int w, rid, i;
    logic [N-1:0] e_ar, e_srv;
    logic e_mrr;
    bit dec;
    @(negedge clk);
    rid = int'(m_rid);
    w = -1;
    if (!md_pend) begin
      for (int k = 0; k < N; k++) begin
        i = RR ? (md_rr + k) % N : k;
        if (w < 0 && s_arvalid[i] && md_cnt[i] < MAX_OUT) w = i;
      end
    end
    e_ar = '0;
    if (w >= 0) e_ar[w] = 1'b1;
    e_srv = '0;
    e_mrr = 1'b1;
    if (rid < N) begin
      e_srv[rid] = m_rvalid;
      e_mrr = s_rready[rid];
    end
    obs_arready = s_arready; obs_srvalid = s_rvalid; obs_mrready = m_rready;
    obs_marvalid = m_arvalid; obs_riderr = rid_err; obs_arid = m_arid;
    obs_araddr = m_araddr; obs_arlen = m_arlen; obs_arburst = m_arburst;
    chk("s_arready", s_arready, e_ar);
    chk("m_arvalid", m_arvalid, md_pend);
    chk("m_araddr", m_araddr, md_addr);
    chk("m_arlen", m_arlen, md_len);
    chk("m_arsize", m_arsize, md_size);
    chk("m_arid", m_arid, md_id);
    chk("m_arburst", m_arburst, (md_len != 0) ? 2'b01 : 2'b00);
    chk("s_rvalid", s_rvalid, e_srv);
    chk("m_rready", m_rready, e_mrr);
    chk("rid_err", rid_err, md_err);
    chk("r_passthru", {s_rdata, s_rresp, s_rlast}, {m_rdata, m_rresp, m_rlast});
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int j = 0; j < N; j++) begin
        dec = m_rvalid && e_mrr && m_rlast && (rid == j);
        if (w == j && !dec) md_cnt[j]++;
        else if (dec && w != j && md_cnt[j] > 0) md_cnt[j]--;
      end
      if (w >= 0) begin
        md_pend = 1'b1;
        md_addr = s_araddr[32*w +: 32];
        md_len  = s_arlen[4*w +: 4];
        md_size = s_arsize[3*w +: 3];
        md_id   = w;
        md_rr   = (w + 1) % N;
      end else if (md_pend && m_arready) begin
        md_pend = 1'b0;
      end
      if (m_rvalid && rid >= N) md_err = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  int grants [4];
  int exp_grants [4];
  int ng;
  int r;

  initial begin
    tbl[0] = '{1'b1, 4'd0, 3'b111, 3'b001, 1'b1};
    tbl[1] = '{1'b1, 4'd0, 3'b110, 3'b001, 1'b0};
    tbl[2] = '{1'b1, 4'd2, 3'b011, 3'b100, 1'b0};
    tbl[3] = '{1'b0, 4'd1, 3'b010, 3'b000, 1'b1};
    tbl[4] = '{1'b1, 4'd1, 3'b101, 3'b010, 1'b0};
    tbl[5] = '{1'b1, 4'd6, 3'b000, 3'b000, 1'b1};

    idle_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    cycle();
    chk("rst_arvalid", obs_marvalid, 1'b0);
    chk("rst_araddr", obs_araddr, 32'h0);
    chk("rst_arid", obs_arid, 4'h0);
    chk("rst_riderr", obs_riderr, 1'b0);

    // R routing vectors
    for (int t = 0; t < 6; t++) begin
      m_rvalid = tbl[t].mrv; m_rid = tbl[t].rid; s_rready = tbl[t].rr;
      m_rdata = 32'hA5A5_0000 + t; m_rlast = 1'b0;
      cycle();
      chk("tbl_srvalid", obs_srvalid, tbl[t].exp_srv);
      chk("tbl_mrready", obs_mrready, tbl[t].exp_mrr);
    end
    do_reset();

    // single read
    set_req(1, 32'h1FC0_0000, 4'd0, 3'd2);
    s_arvalid = 3'b010;
    cycle();
    chk("t1_grant", obs_arready, 3'b010);
    s_arvalid = '0; m_arready = 1'b1;
    cycle();
    chk("t1_arvalid", obs_marvalid, 1'b1);
    chk("t1_arid", obs_arid, 4'd1);
    chk("t1_arburst", obs_arburst, 2'b00);
    chk("t1_araddr", obs_araddr, 32'h1FC0_0000);
    m_arready = 1'b0; m_rvalid = 1'b1; m_rid = 4'd1; m_rlast = 1'b1; s_rready = 3'b111;
    cycle();
    chk("t1_srvalid", obs_srvalid, 3'b010);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    cycle();
    do_reset();

    // contention
    for (int i = 0; i < N; i++) set_req(i, 32'h1000 * (i + 1), 4'd1, 3'd2);
    s_arvalid = 3'b111; m_arready = 1'b1;
    ng = 0;
    for (int c = 0; c < 12 && ng < 4; c++) begin
      cycle();
      if (obs_arready != '0) begin
        grants[ng] = oh_idx(obs_arready);
        ng++;
      end
    end
    chk("t2_grant_count", ng, 4);
    if (RR) exp_grants = '{0, 1, 2, 0};
    else    exp_grants = '{0, 0, 1, 1};
    for (int g = 0; g < 4; g++) chk("t2_grant_order", grants[g], exp_grants[g]);
    do_reset();

    // outstanding limit
    set_req(0, 32'h0000_4000, 4'd3, 3'd2);
    set_req(2, 32'h0000_8000, 4'd0, 3'd2);
    m_arready = 1'b1;
    s_arvalid = 3'b001; cycle(); chk("t3_g0a", obs_arready, 3'b001);
    cycle();
    cycle(); chk("t3_g0b", obs_arready, 3'b001);
    cycle();
    s_arvalid = 3'b101; cycle(); chk("t3_g2", obs_arready, 3'b100);
    s_arvalid = '0; cycle();
    m_rvalid = 1'b1; m_rid = 4'd0; m_rlast = 1'b1;
    cycle();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    s_arvalid = 3'b001; cycle(); chk("t3_g0c", obs_arready, 3'b001);
    s_arvalid = '0; cycle();
    do_reset();

    // backpressure
    set_req(0, 32'h8000_1000, 4'd3, 3'd2);
    s_arvalid = 3'b001; m_arready = 1'b0;
    cycle();
    s_arvalid = 3'b111;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("t4_arvalid", obs_marvalid, 1'b1);
      chk("t4_araddr", obs_araddr, 32'h8000_1000);
      chk("t4_arlen", obs_arlen, 4'd3);
      chk("t4_arid", obs_arid, 4'd0);
      chk("t4_no_grant", obs_arready, 3'b000);
    end
    m_rvalid = 1'b1; m_rid = 4'd0; s_rready = 3'b110;
    cycle();
    chk("t4_mrready", obs_mrready, 1'b0);
    m_rvalid = 1'b0; s_rready = 3'b111; s_arvalid = '0; m_arready = 1'b1;
    cycle();
    do_reset();

    // same-cycle increment and decrement
    set_req(1, 32'h0000_2000, 4'd0, 3'd2);
    m_arready = 1'b1;
    s_arvalid = 3'b010; cycle(); chk("t5_g1", obs_arready, 3'b010);
    s_arvalid = '0; cycle();
    s_arvalid = 3'b010; m_rvalid = 1'b1; m_rid = 4'd1; m_rlast = 1'b1;
    cycle(); chk("t5_g2", obs_arready, 3'b010);
    s_arvalid = '0; m_rvalid = 1'b0; m_rlast = 1'b0; cycle();
    s_arvalid = 3'b010; cycle(); chk("t5_g3", obs_arready, 3'b010);
    s_arvalid = '0; cycle();
    s_arvalid = 3'b010; cycle(); chk("t5_stall", obs_arready, 3'b000);
    do_reset();

    // bad ID
    m_rvalid = 1'b1; m_rid = 4'd5; s_rready = 3'b000;
    cycle();
    chk("t6_mrready", obs_mrready, 1'b1);
    chk("t6_srvalid", obs_srvalid, 3'b000);
    m_rvalid = 1'b0; s_rready = 3'b111;
    cycle(); chk("t6_err", obs_riderr, 1'b1);
    cycle(); cycle(); chk("t6_err_sticky", obs_riderr, 1'b1);
    do_reset();
    cycle(); chk("t6_err_clr", obs_riderr, 1'b0);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) do_reset();
      s_arvalid = N'($urandom);
      for (int i = 0; i < N; i++) set_req(i, $urandom, 4'($urandom), 3'($urandom));
      s_rready  = N'($urandom);
      m_arready = 1'($urandom);
      m_rvalid  = 1'($urandom);
      m_rlast   = 1'($urandom);
      m_rdata   = $urandom;
      m_rresp   = 2'($urandom);
      r = $urandom_range(0, 15);
      m_rid = (r < 13) ? ID_W'(r % N) : ID_W'(r);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
